// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit controller.
//   md_op_e      : operation codes driven by the EX-stage instruction decode
//   state_e      : controller FSM states (also visible on the debug output)
//   mul64/abs32  : arithmetic helpers used by the controller
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int MUL_LAT_DEF  = 2;
  localparam int DIV_ITER_DEF = 32;

  // 33-bit extended operands cover both signed and unsigned products; the
  // 66-bit result is truncated to the architectural 64 bits.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [32:0] sa;
    logic signed [32:0] sb;
    logic signed [65:0] p;
    sa = $signed({sgn & a[31], a});
    sb = $signed({sgn & b[31], b});
    p  = sa * sb;
    return p[63:0];
  endfunction

  // Magnitude of a signed operand; unsigned operands pass through.
  // abs(-2^31) stays 32'h80000000, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline <-> multiply/divide unit bundle.
// Handshake: md_valid/md_op/md_rs/md_rt describe the instruction in EX. While
// md_stall=1 the pipeline holds them stable; the instruction retires from EX
// at the first rising edge where md_stall=0, and any HI/LO write lands at that
// same edge. md_cancel flushes the EX instruction and overrides everything.
//   master : pipeline side (drives request, reads stall/busy/HI/LO)
//   slave  : mdu_ctrl side
interface mdu_if;
  import mdu_pkg::*;

  logic        md_valid;
  md_op_e      md_op;
  logic [31:0] md_rs;
  logic [31:0] md_rt;
  logic        md_cancel;
  logic        md_stall;
  logic        md_busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output md_valid, md_op, md_rs, md_rt, md_cancel,
    input  md_stall, md_busy, hi_o, lo_o
  );

  modport slave (
    input  md_valid, md_op, md_rs, md_rt, md_cancel,
    output md_stall, md_busy, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_ctrl_div_iter.sv
// Radix-2 restoring divider datapath, one quotient bit per step.
//   clk, resetn         : clock, async active-low reset
//   start               : load dividend/divisor magnitudes, clear counter
//   step                : perform one shift-subtract iteration
//   dividend, divisor   : unsigned magnitudes
//   quotient, remainder : running results (final once done=1)
//   count, done         : iterations performed, all iterations complete
module div_iter
  import mdu_pkg::*;
#(
  parameter int DIV_ITER = DIV_ITER_DEF,
  localparam int CW = $clog2(DIV_ITER + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          step,
  input  logic [31:0]   dividend,
  input  logic [31:0]   divisor,
  output logic [31:0]   quotient,
  output logic [32:0]   remainder,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [31:0] dvs;
  logic [32:0] shifted;
  logic [33:0] diff;

  // The quotient register starts out holding the dividend; its MSB shifts
  // into the partial remainder as each quotient bit shifts in at the bottom.
  always_comb begin
    shifted = {remainder[31:0], quotient[31]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
      count     <= '0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
      count     <= '0;
    end else if (step && !done) begin
      if (!diff[33]) begin
        remainder <= diff[32:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= shifted;
        quotient  <= {quotient[30:0], 1'b0};
      end
      count <= count + 1'b1;
    end
  end

  assign done = (count == CW'(DIV_ITER));

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the EX stage: owns HI/LO, sequences
// MULT/MULTU/DIV/DIVU over several cycles and applies MTHI/MTLO at once.
//   clk, resetn : clock, async active-low reset
//   md          : mdu_if.slave (request, stall, busy, HI/LO)
//   state_dbg   : current FSM state
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic   clk,
  input  logic   resetn,
  mdu_if.slave   md,
  output state_e state_dbg
);

  localparam int CW = $clog2(DIV_ITER + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_ITER - 1);
  // MUL state occupies MUL_LAT-2 cycles, so its last cycle has count MUL_LAT-3.
  localparam logic [1:0] MUL_LAST = (MUL_LAT > 2) ? 2'(MUL_LAT - 3) : 2'd0;

  state_e      state, state_n;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  md_op_e      op_q;
  logic [31:0] rs_q, rt_q;
  logic [1:0]  mul_cnt;
  logic        go, stall_c, accept, div_start, div_step;

  logic [31:0]   div_quo;
  logic [32:0]   div_rem;
  logic [CW-1:0] div_count;
  logic          div_done;
  logic          unused_rem_msb;

  logic [63:0] prod_q, prod_live;
  logic        div_sgn, neg_q, neg_r;
  logic [31:0] q_fix, r_fix, res_hi, res_lo;

  div_iter #(.DIV_ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .step      (div_step),
    .dividend  (abs32(md.md_rs, md.md_op == OP_DIV)),
    .divisor   (abs32(md.md_rt, md.md_op == OP_DIV)),
    .quotient  (div_quo),
    .remainder (div_rem),
    .count     (div_count),
    .done      (div_done)
  );

  // The partial remainder is always below the divisor once complete, so its
  // top bit is only carry headroom inside the datapath.
  assign unused_rem_msb = div_rem[32];

  // A missing md_valid mid-operation is treated exactly like a cancel.
  assign go = md.md_valid & ~md.md_cancel;

  // Result formation for the DONE cycle, from the operands latched at accept.
  always_comb begin
    prod_q    = mul64(rs_q, rt_q, op_q == OP_MULT);
    prod_live = mul64(md.md_rs, md.md_rt, md.md_op == OP_MULT);
    div_sgn   = (op_q == OP_DIV);
    neg_q     = div_sgn & (rs_q[31] ^ rt_q[31]);
    neg_r     = div_sgn & rs_q[31];
    q_fix     = neg_q ? (~div_quo + 32'd1) : div_quo;
    r_fix     = neg_r ? (~div_rem[31:0] + 32'd1) : div_rem[31:0];
    if (op_q == OP_MULT || op_q == OP_MULTU) begin
      res_hi = prod_q[63:32];
      res_lo = prod_q[31:0];
    end else if (rt_q == 32'd0) begin
      // Divide by zero: no trap, fixed pattern in LO, raw dividend in HI.
      res_hi = rs_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = r_fix;
      res_lo = q_fix;
    end
  end

  always_comb begin
    state_n   = state;
    stall_c   = 1'b0;
    accept    = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state)
      ST_IDLE: begin
        if (go) begin
          case (md.md_op)
            OP_MTHI: hi_d = md.md_rs;
            OP_MTLO: lo_d = md.md_rs;
            OP_MULT, OP_MULTU: begin
              if (MUL_LAT == 1) begin
                // Single-cycle multiply: the accept cycle is the done cycle.
                hi_d = prod_live[63:32];
                lo_d = prod_live[31:0];
              end else begin
                accept  = 1'b1;
                stall_c = 1'b1;
                state_n = (MUL_LAT == 2) ? ST_DONE : ST_MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
              accept    = 1'b1;
              div_start = 1'b1;
              stall_c   = 1'b1;
              state_n   = ST_DIV;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (!go) begin
          state_n = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          if (mul_cnt == MUL_LAST) state_n = ST_DONE;
        end
      end
      ST_DIV: begin
        if (!go) begin
          state_n = ST_IDLE;
        end else begin
          stall_c  = 1'b1;
          div_step = ~div_done;
          if (div_count == DIV_LAST) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (go) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= OP_NONE;
      rs_q    <= '0;
      rt_q    <= '0;
      mul_cnt <= '0;
    end else begin
      state <= state_n;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      if (accept) begin
        op_q    <= md.md_op;
        rs_q    <= md.md_rs;
        rt_q    <= md.md_rt;
        mul_cnt <= '0;
      end else if (state == ST_MUL) begin
        mul_cnt <= mul_cnt + 2'd1;
      end
    end
  end

  // Stall is forced low while reset is held, so the pipeline is never frozen
  // by a request that arrives during reset.
  assign md.md_stall = stall_c & resetn;
  assign md.md_busy  = (state != ST_IDLE);
  assign md.hi_o     = hi_q;
  assign md.lo_o     = lo_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_pkg::*;

  typedef struct {
    md_op_e      op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          stalls;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic   clk;
  logic   resetn;
  state_e state_dbg;
  int     n_checks;
  int     n_fail;
  vec_t   vecs[13];

  mdu_if bus();

  mdu_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .md        (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one instruction in EX and holds it until md_stall falls; the
  // instruction retires on the following rising edge.
  task automatic do_op(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls);
    int n;
    bit fin;
    @(posedge clk); #1;
    bus.md_valid  = 1'b1;
    bus.md_op     = op;
    bus.md_rs     = rs;
    bus.md_rt     = rt;
    bus.md_cancel = 1'b0;
    stalls = 0;
    n = 0;
    fin = 1'b0;
    while (!fin && n < 200) begin
      @(negedge clk);
      if (bus.md_stall) stalls++;
      else fin = 1'b1;
      n++;
    end
    check("stall_timeout", {31'b0, fin}, 32'd1);
    @(posedge clk); #1;
    bus.md_valid = 1'b0;
    bus.md_op    = OP_NONE;
  endtask

  task automatic idle_inputs();
    bus.md_valid  = 1'b0;
    bus.md_op     = OP_NONE;
    bus.md_rs     = '0;
    bus.md_rt     = '0;
    bus.md_cancel = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int st;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        1,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_DIVU,  32'd100,       32'd7,        33, 32'd2,         32'd14};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIV,   32'd5,         32'd0,        33, 32'd5,         32'hFFFF_FFFF};
    vecs[4]  = '{OP_MTHI,  32'hDEAD_BEEF, 32'd0,        0,  32'hDEAD_BEEF, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_MTLO,  32'h1234_5678, 32'd0,        0,  32'hDEAD_BEEF, 32'h1234_5678};
    vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,        32'h8000_0000};
    vecs[7]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'd1,        32'hFFFF_FFFD};
    vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd16,       33, 32'd15,        32'h0FFF_FFFF};
    vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'd0};
    vecs[11] = '{OP_NONE,  32'h1111_1111, 32'h2222_2222, 0, 32'h4000_0000, 32'd0};
    vecs[12] = '{OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFE, 32'd2};

    // Reset state
    resetn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi",    bus.hi_o, 32'd0);
    check("rst_lo",    bus.lo_o, 32'd0);
    check("rst_busy",  {31'b0, bus.md_busy}, 32'd0);
    check("rst_stall", {31'b0, bus.md_stall}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven vectors; HI/LO expectations accumulate in table order.
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, st);
      check($sformatf("v%0d_stalls", i), 32'(st), 32'(vecs[i].stalls));
      check($sformatf("v%0d_hi", i), bus.hi_o, vecs[i].hi);
      check($sformatf("v%0d_lo", i), bus.lo_o, vecs[i].lo);
      check($sformatf("v%0d_idle", i), 32'(state_dbg), 32'(ST_IDLE));
    end

    // DIV cancelled during iteration 10
    @(posedge clk); #1;
    bus.md_valid = 1'b1;
    bus.md_op    = OP_DIV;
    bus.md_rs    = 32'd100;
    bus.md_rt    = 32'd3;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("cxl_pre_stall", {31'b0, bus.md_stall}, 32'd1);
    check("cxl_pre_busy",  {31'b0, bus.md_busy}, 32'd1);
    check("cxl_pre_state", 32'(state_dbg), 32'(ST_DIV));
    @(posedge clk); #1;
    bus.md_cancel = 1'b1;
    @(negedge clk);
    check("cxl_stall", {31'b0, bus.md_stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    check("cxl_state", 32'(state_dbg), 32'(ST_IDLE));
    check("cxl_busy",  {31'b0, bus.md_busy}, 32'd0);
    check("cxl_hi",    bus.hi_o, vecs[12].hi);
    check("cxl_lo",    bus.lo_o, vecs[12].lo);

    // MTLO flushed by cancel leaves LO alone
    @(posedge clk); #1;
    bus.md_valid  = 1'b1;
    bus.md_op     = OP_MTLO;
    bus.md_rs     = 32'hAAAA_5555;
    bus.md_cancel = 1'b1;
    @(negedge clk);
    check("mtlo_cxl_stall", {31'b0, bus.md_stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    check("mtlo_cxl_lo", bus.lo_o, vecs[12].lo);

    // Multiply after the cancelled divide
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, st);
    check("mulu_stalls", 32'(st), 32'd1);
    check("mulu_hi", bus.hi_o, 32'd1);
    check("mulu_lo", bus.lo_o, 32'hFFFF_FFFE);

    // Reset asserted mid-DIV, then a fresh DIVU
    @(posedge clk); #1;
    bus.md_valid = 1'b1;
    bus.md_op    = OP_DIVU;
    bus.md_rs    = 32'd1000;
    bus.md_rt    = 32'd33;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("mrst_hi",    bus.hi_o, 32'd0);
    check("mrst_lo",    bus.lo_o, 32'd0);
    check("mrst_busy",  {31'b0, bus.md_busy}, 32'd0);
    check("mrst_stall", {31'b0, bus.md_stall}, 32'd0);
    check("mrst_state", 32'(state_dbg), 32'(ST_IDLE));
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    do_op(OP_DIVU, 32'd1000, 32'd33, st);
    check("post_rst_stalls", 32'(st), 32'd33);
    check("post_rst_hi", bus.hi_o, 32'd10);
    check("post_rst_lo", bus.lo_o, 32'd30);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
